// File: rtl/neo_reset_seq_pkg.sv
// neo_reset_pkg: shared types and constants for the neo_reset_seq sequencer.
//   state_t    sequencer states
//   CAUSE_*    codes reported on cause
//   CNT_W      hold counter width
package neo_reset_pkg;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {ST_POR, ST_HOLD, ST_REL_S, ST_REL_R, ST_ACK, ST_WAIT_DROP, ST_IDLE} state_t;
  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_REQ = 2'd1;
  localparam logic [1:0] CAUSE_WD  = 2'd2;
endpackage

// File: rtl/neo_reset_seq_if.sv
// neo_reset_seq_if: requester/strobe bundle of the reset sequencer.
//   master: requester side (drives req, wd_kick; observes strobes and status)
//   slave:  sequencer side (drives nS_CELLS, nR_CELLS, ack, busy, cause, grant_idx)
interface neo_reset_seq_if #(parameter int NREQ = 3);
  logic [NREQ-1:0] req;
  logic            wd_kick;
  logic            nS_CELLS;
  logic            nR_CELLS;
  logic [NREQ-1:0] ack;
  logic            busy;
  logic [1:0]      cause;
  logic [1:0]      grant_idx;
  modport master (output req, wd_kick, input nS_CELLS, nR_CELLS, ack, busy, cause, grant_idx);
  modport slave  (input req, wd_kick, output nS_CELLS, nR_CELLS, ack, busy, cause, grant_idx);
endinterface

// File: rtl/neo_wd_counter.sv
// neo_wd_counter: idle watchdog; counts IDLE cycles, fires at WD_CYCLES-1 without a kick.
//   CK, nRESET  clock, async active-low reset
//   kick        restart pulse
//   run         high while the sequencer is IDLE; low clears the count
//   fire        timeout reached this cycle
module neo_wd_counter #(
  parameter int WD_CYCLES = 65536
) (
  input  logic CK,
  input  logic nRESET,
  input  logic kick,
  input  logic run,
  output logic fire
);
  logic [19:0] cnt;
  assign fire = run && !kick && cnt == 20'(WD_CYCLES - 1);
  always_ff @(posedge CK or negedge nRESET)
    if (!nRESET) cnt <= '0;
    else cnt <= (kick || !run) ? '0 : cnt + 20'd1;
endmodule

// File: rtl/neo_reset_seq.sv
// neo_reset_seq: shares staggered FD/FDP set/clear strobes between POR, requesters and watchdog.
//   CK      system clock
//   nRESET  async active-low reset, power-on source
//   bus     neo_reset_seq_if.slave: req/wd_kick in; nS_CELLS, nR_CELLS, ack, busy, cause, grant_idx out
// Optional watchdog built when NEO_RST_WATCHDOG_EN is defined.
module neo_reset_seq import neo_reset_pkg::*; #(
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int WD_CYCLES   = 65536
) (
  input logic            CK,
  input logic            nRESET,
  neo_reset_seq_if.slave bus
);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       cause, cause_n, gidx, gidx_n, win;
  logic             fire;
`ifdef NEO_RST_WATCHDOG_EN
  neo_wd_counter #(.WD_CYCLES(WD_CYCLES)) u_wd (
    .CK(CK), .nRESET(nRESET), .kick(bus.wd_kick), .run(state == ST_IDLE), .fire(fire)
  );
`else
  assign fire = 1'b0;
`endif
  assign bus.cause     = cause;
  assign bus.grant_idx = gidx;
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (bus.req[i]) win = 2'(i);
    state_n = state;
    cnt_n   = cnt;
    cause_n = cause;
    gidx_n  = gidx;
    case (state)
      ST_POR: begin
        state_n = ST_HOLD;
        cnt_n   = CNT_W'(HOLD_CYCLES - 1);
      end
      ST_HOLD: if (cnt == '0) state_n = ST_REL_S; else cnt_n = cnt - 1'b1;
      ST_REL_S: state_n = ST_REL_R;
      ST_REL_R: state_n = (cause == CAUSE_REQ) ? ST_ACK : ST_IDLE;
      ST_ACK: state_n = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!bus.req[gidx]) state_n = ST_IDLE;
      ST_IDLE: if (fire || |bus.req) begin
        state_n = ST_HOLD;
        cnt_n   = CNT_W'(HOLD_CYCLES - 1);
        cause_n = fire ? CAUSE_WD : CAUSE_REQ;
        gidx_n  = fire ? gidx : win;
      end
      default: state_n = ST_POR;
    endcase
  end
  // Strobes, ack and busy are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge CK or negedge nRESET)
    if (!nRESET) begin
      state        <= ST_POR;
      cnt          <= '0;
      cause        <= CAUSE_POR;
      gidx         <= '0;
      bus.nS_CELLS <= 1'b0;
      bus.nR_CELLS <= 1'b0;
      bus.ack      <= '0;
      bus.busy     <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cause        <= cause_n;
      gidx         <= gidx_n;
      bus.nS_CELLS <= !(state == ST_POR || state == ST_HOLD);
      bus.nR_CELLS <= state inside {ST_REL_R, ST_ACK, ST_WAIT_DROP, ST_IDLE};
      bus.ack      <= (state == ST_ACK) ? NREQ'(1) << gidx : '0;
      bus.busy     <= state != ST_IDLE;
    end
endmodule

// File: tb/tb_neo_reset_seq.sv
// tb_neo_reset_seq: scoreboard bench for neo_reset_seq with a transaction-level arbitration model.
module tb_neo_reset_seq;
  import neo_reset_pkg::*;
  localparam int NREQ = 3, H = 16, WD = 100;
  logic CK = 0, nRESET = 0;
  neo_reset_seq_if #(.NREQ(NREQ)) bus ();
  neo_reset_seq #(.NREQ(NREQ), .HOLD_CYCLES(H), .WD_CYCLES(WD)) dut (.CK(CK), .nRESET(nRESET), .bus(bus));
  always #5 CK = ~CK;

  typedef struct {logic [1:0] cause; logic [1:0] gidx; int n;} seq_t;
  typedef struct {logic [NREQ-1:0] mask; int at;} ack_t;
  seq_t seq_q[$];
  ack_t ack_q[$];
  int plan_idx[$], plan_at[$];
  int checks = 0, failures = 0, cyc = 0;
  int t_free = 1 << 30, wd_base = 1 << 30, kick_per = 1;
  logic [NREQ-1:0] pending = '0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge CK);
    cyc++;
  end

  // Monitor: pops expectations when a sequence completes (nR_CELLS rises) or an ack appears.
  initial begin
    logic prev_ns, prev_nr;
    int ns_rise, ns_fall;
    seq_t e;
    ack_t a;
    prev_ns = 0; prev_nr = 0; ns_rise = 0; ns_fall = 0;
    forever begin
      @(negedge CK);
      if (!nRESET) begin
        prev_ns = 0;
        prev_nr = 0;
      end else begin
        if (!prev_ns && bus.nS_CELLS) ns_rise = cyc;
        if (prev_ns && !bus.nS_CELLS) ns_fall = cyc;
        check("strobe_order", int'(bus.nR_CELLS && !bus.nS_CELLS), 0);
        if (!prev_nr && bus.nR_CELLS) begin
          if (seq_q.size() == 0) check("unexpected_seq", cyc, -1);
          else begin
            e = seq_q.pop_front();
            check("nR_rise_edge", cyc, e.n + H + 2);
            check("nS_rise_edge", ns_rise, e.n + H + 1);
            if (e.cause != CAUSE_POR) check("nS_fall_edge", ns_fall, e.n + 1);
            check("cause", bus.cause, e.cause);
            if (e.cause == CAUSE_REQ) check("grant_idx", bus.grant_idx, e.gidx);
          end
        end
        if (bus.ack != '0) begin
          if (ack_q.size() == 0) check("unexpected_ack", bus.ack, 0);
          else begin
            a = ack_q.pop_front();
            check("ack_mask", bus.ack, a.mask);
            check("ack_edge", cyc, a.at);
          end
        end
        prev_ns = bus.nS_CELLS;
        prev_nr = bus.nR_CELLS;
      end
    end
  end

  // One clock of stimulus plus the model's view of edge e (the edge that samples these inputs).
  task automatic cycle_step(bit rnd);
    int e, w;
    logic [NREQ-1:0] dropped;
    bit fire_m;
    @(posedge CK);
    #1;
    e = cyc + 1;
    dropped = '0;
    fire_m = 0;
    for (int i = 0; i < NREQ; i++)
      if (bus.req[i] && bus.ack[i]) begin
        bus.req[i] = 1'b0;
        dropped[i] = 1'b1;
      end
    for (int k = plan_at.size() - 1; k >= 0; k--)
      if (plan_at[k] <= e && !bus.req[plan_idx[k]] && !dropped[plan_idx[k]]) begin
        bus.req[plan_idx[k]] = 1'b1;
        pending[plan_idx[k]] = 1'b1;
        plan_at.delete(k);
        plan_idx.delete(k);
      end
    if (rnd)
      for (int i = 0; i < NREQ; i++)
        if (!bus.req[i] && !dropped[i] && $urandom_range(0, 11) == 0) begin
          bus.req[i] = 1'b1;
          pending[i] = 1'b1;
        end
    bus.wd_kick = kick_per == 1 || (kick_per > 1 && e % kick_per == 0);
    if (bus.wd_kick && e + 1 > wd_base) wd_base = e + 1;
`ifdef NEO_RST_WATCHDOG_EN
    fire_m = (e == wd_base + WD - 1);
`endif
    if (e == t_free) begin
      if (fire_m) begin
        seq_q.push_back('{CAUSE_WD, 2'd0, e});
        t_free = e + H + 3;
        wd_base = t_free;
      end else if (pending != '0) begin
        w = 0;
        while (!pending[w]) w++;
        pending[w] = 1'b0;
        seq_q.push_back('{CAUSE_REQ, 2'(w), e});
        ack_q.push_back('{NREQ'(1) << w, e + H + 3});
        t_free = e + H + 5;
        wd_base = t_free;
      end else t_free = e + 1;
    end
  endtask

  task automatic reset_checks();
    check("rst_nS", bus.nS_CELLS, 0);
    check("rst_nR", bus.nR_CELLS, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_cause", bus.cause, 0);
    check("rst_grant_idx", bus.grant_idx, 0);
  endtask

  task automatic release_reset();
    @(negedge CK);
    nRESET = 1'b1;
    seq_q.push_back('{CAUSE_POR, 2'd0, cyc + 1});
    t_free = cyc + 1 + H + 3;
    wd_base = t_free;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((seq_q.size() != 0 || ack_q.size() != 0 || pending != '0 || plan_at.size() != 0) && n < 3000) begin
      cycle_step(0);
      n++;
    end
    repeat (H + 10) cycle_step(0);
    check("seq_q_empty", seq_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    check("idle_busy", bus.busy, 0);
  endtask

  task automatic plan(int idx, int at);
    plan_idx.push_back(idx);
    plan_at.push_back(at);
  endtask

  initial begin
    bus.req = '0;
    bus.wd_kick = 1'b1;
    repeat (3) @(posedge CK);
    #1;
    reset_checks();
    release_reset();
    drain();
    plan(1, cyc + 3);
    drain();
    plan(1, cyc + 3);
    plan(2, cyc + 3);
    drain();
    plan(2, cyc + 3);
    plan(0, cyc + 3 + H + 1);
    drain();
    plan(1, cyc + 3);
    repeat (8) cycle_step(0);
    nRESET = 1'b0;
    #1;
    reset_checks();
    seq_q.delete();
    ack_q.delete();
    plan_idx.delete();
    plan_at.delete();
    pending = '0;
    bus.req = '0;
    t_free = 1 << 30;
    repeat (3) @(posedge CK);
    release_reset();
    drain();
    repeat (600) cycle_step(1);
    drain();
    kick_per = 50;
    repeat (300) cycle_step(0);
    kick_per = 0;
    repeat (WD + 10) cycle_step(0);
    kick_per = 1;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
